// File: rtl/axis_packet_classifier.sv
// AXI-Stream register slice that classifies each packet from its head beat
// (IPv4 source address / TCP-UDP destination port block list) and counts packets.
module axis_packet_classifier #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic [15:0]           s_axis_tuser_size,
    input  logic [15:0]           s_axis_tuser_src,
    input  logic [15:0]           s_axis_tuser_dst,
    output logic                  s_axis_tready,

    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [15:0]           m_axis_tuser_size,
    output logic [15:0]           m_axis_tuser_src,
    output logic [15:0]           m_axis_tuser_dst,
    input  logic                  m_axis_tready,

    output logic                  decision_valid,
    output logic                  decision_allow,

    input  logic                  cfg_enable,
    input  logic [31:0]           cfg_block_ip,
    input  logic [15:0]           cfg_block_port,

    output logic [31:0]           cnt_pkts,
    output logic [31:0]           cnt_blocked
);

    typedef enum logic {
        ST_HEAD,
        ST_BODY
    } state_t;

    state_t      state;
    logic        capture;
    logic        is_head;
    logic        block;
    logic [15:0] ethertype;
    logic [3:0]  ihl;
    logic [7:0]  protocol;
    logic [31:0] src_ip;
    logic [15:0] dst_port;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign capture       = s_axis_tvalid && s_axis_tready;
    assign is_head       = (state == ST_HEAD);

    // Byte n sits at tdata[8n +: 8]; header fields are big-endian across bytes.
    assign ethertype = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    assign ihl       = s_axis_tdata[8*14 +: 4];
    assign protocol  = s_axis_tdata[8*23 +: 8];
    assign src_ip    = {s_axis_tdata[8*26 +: 8], s_axis_tdata[8*27 +: 8],
                        s_axis_tdata[8*28 +: 8], s_axis_tdata[8*29 +: 8]};
    assign dst_port  = {s_axis_tdata[8*36 +: 8], s_axis_tdata[8*37 +: 8]};

    always_comb begin
        block = 1'b0;
        if (cfg_enable && ethertype == 16'h0800) begin
            if (src_ip == cfg_block_ip)
                block = 1'b1;
            else if (cfg_block_port != 16'd0 && ihl == 4'd5 &&
                     (protocol == 8'd6 || protocol == 8'd17) &&
                     dst_port == cfg_block_port)
                block = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_HEAD;
            m_axis_tvalid     <= 1'b0;
            m_axis_tdata      <= '0;
            m_axis_tkeep      <= '0;
            m_axis_tlast      <= 1'b0;
            m_axis_tuser_size <= '0;
            m_axis_tuser_src  <= '0;
            m_axis_tuser_dst  <= '0;
            decision_valid    <= 1'b0;
            decision_allow    <= 1'b0;
            cnt_pkts          <= '0;
            cnt_blocked       <= '0;
        end else if (capture) begin
            m_axis_tvalid     <= 1'b1;
            m_axis_tdata      <= s_axis_tdata;
            m_axis_tkeep      <= s_axis_tkeep;
            m_axis_tlast      <= s_axis_tlast;
            m_axis_tuser_size <= s_axis_tuser_size;
            m_axis_tuser_src  <= s_axis_tuser_src;
            m_axis_tuser_dst  <= s_axis_tuser_dst;
            decision_valid    <= is_head;
            state             <= s_axis_tlast ? ST_HEAD : ST_BODY;
            // Decision is frozen with the head beat; body beats leave it untouched.
            if (is_head) begin
                decision_allow <= !block;
                cnt_pkts       <= cnt_pkts + 32'd1;
                if (block)
                    cnt_blocked <= cnt_blocked + 32'd1;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid  <= 1'b0;
            decision_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_packet_classifier.sv
// Scoreboard bench for axis_packet_classifier: directed packets push expected
// beats, a negedge monitor pops and compares on each egress handshake.
module tb_axis_packet_classifier;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic [15:0]   s_size, s_src, s_dst;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [15:0]   m_size, m_src, m_dst;
    logic          m_tready;
    logic          dec_valid, dec_allow;
    logic          cfg_enable;
    logic [31:0]   cfg_block_ip;
    logic [15:0]   cfg_block_port;
    logic [31:0]   cnt_pkts, cnt_blocked;

    axis_packet_classifier #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tuser_size(s_size), .s_axis_tuser_src(s_src),
        .s_axis_tuser_dst(s_dst), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tuser_size(m_size), .m_axis_tuser_src(m_src),
        .m_axis_tuser_dst(m_dst), .m_axis_tready(m_tready),
        .decision_valid(dec_valid), .decision_allow(dec_allow),
        .cfg_enable(cfg_enable), .cfg_block_ip(cfg_block_ip), .cfg_block_port(cfg_block_port),
        .cnt_pkts(cnt_pkts), .cnt_blocked(cnt_blocked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          head;
        logic          allow;
        logic [15:0]   size;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   dec_cnt = 0;
    int   seq = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_head(input logic [15:0] et, input logic [3:0] ihl,
                                              input logic [7:0] proto, input logic [31:0] ip,
                                              input logic [15:0] dp);
        logic [DW-1:0] d;
        for (int i = 0; i < KW; i++) d[8*i +: 8] = 8'(i + 8'h40);
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
        d[8*14 +: 8] = {4'h4, ihl};
        d[8*23 +: 8] = proto;
        d[8*26 +: 8] = ip[31:24];
        d[8*27 +: 8] = ip[23:16];
        d[8*28 +: 8] = ip[15:8];
        d[8*29 +: 8] = ip[7:0];
        d[8*36 +: 8] = dp[15:8];
        d[8*37 +: 8] = dp[7:0];
        return d;
    endfunction

    function automatic logic [DW-1:0] mk_body(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = 32'hB0D0_0000 + 32'(n * 16 + i);
        return d;
    endfunction

    // Drives one beat (valid stays high on return) and records its expected egress.
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                        input logic head, input logic allow, output int waits);
        exp_t e;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = last;
        s_size   = 16'(seq);
        waits    = 0;
        @(negedge clk);
        while (!s_tready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!s_tready) begin
            total++;
            bad++;
            $display("FAIL ingress_timeout: got tready=0 expected 1");
        end else begin
            e.data = d; e.keep = k; e.last = last; e.head = head; e.allow = allow;
            e.size = 16'(seq);
            sb.push_back(e);
            seq++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL egress_unexpected: got beat %h expected none", m_tdata[63:0]);
            end else begin
                mon_e = sb.pop_front();
                chk_data("egress_tdata", m_tdata, mon_e.data);
                chk("egress_tkeep", 64'(m_tkeep), 64'(mon_e.keep));
                chk("egress_tlast", 64'(m_tlast), 64'(mon_e.last));
                chk("egress_size", 64'(m_size), 64'(mon_e.size));
                chk("egress_src", 64'(m_src), 64'h1111);
                chk("egress_dst", 64'(m_dst), 64'h2222);
                chk("decision_valid", 64'(dec_valid), 64'(mon_e.head));
                if (mon_e.head) chk("decision_allow", 64'(dec_allow), 64'(mon_e.allow));
                if (dec_valid) dec_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] h;
    logic [KW-1:0] all_keep;
    int            w, wsum, dec0;

    initial begin
        all_keep = '1;
        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        s_size = '0; s_src = 16'h1111; s_dst = 16'h2222;
        m_tready = 1'b1;
        cfg_enable = 1'b1; cfg_block_ip = 32'h0A00_0005; cfg_block_port = 16'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 0);
        chk("rst_dec_valid", 64'(dec_valid), 0);
        chk("rst_dec_allow", 64'(dec_allow), 0);
        chk_data("rst_tdata", m_tdata, '0);
        chk("rst_tkeep", 64'(m_tkeep), 0);
        chk("rst_tlast", 64'(m_tlast), 0);
        chk("rst_cnt_pkts", 64'(cnt_pkts), 0);
        chk("rst_cnt_blocked", 64'(cnt_blocked), 0);
        chk("rst_s_tready", 64'(s_tready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // UDP from 10.0.0.5 dport 53, blocked by source IP; partial tkeep still classified
        h = mk_head(16'h0800, 4'd5, 8'd17, 32'h0A00_0005, 16'd53);
        send(h, 64'h0000_0000_0000_FFFF, 1'b1, 1'b1, 1'b0, w);
        idle();
        @(negedge clk);
        chk("udp_latency_tvalid", 64'(m_tvalid), 1);
        chk("udp_latency_dvalid", 64'(dec_valid), 1);
        chk("udp_latency_allow", 64'(dec_allow), 0);
        chk("udp_cnt_pkts", 64'(cnt_pkts), 1);
        chk("udp_cnt_blocked", 64'(cnt_blocked), 1);
        @(posedge clk); #1;

        // 3-beat TCP dport 80 blocked by port, head stalled 4 cycles
        cfg_block_ip = 32'hC0A8_0001; cfg_block_port = 16'd80;
        m_tready = 1'b0;
        h = mk_head(16'h0800, 4'd5, 8'd6, 32'h0B0B_0B0B, 16'd80);
        send(h, all_keep, 1'b0, 1'b1, 1'b0, w);
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_data("stall_tdata", m_tdata, h);
            chk("stall_tvalid", 64'(m_tvalid), 1);
            chk("stall_dvalid", 64'(dec_valid), 1);
            chk("stall_allow", 64'(dec_allow), 0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        send(mk_body(1), all_keep, 1'b0, 1'b0, 1'b0, w);
        send(mk_body(2), all_keep, 1'b1, 1'b0, 1'b0, w);
        idle();
        @(negedge clk);
        chk("tcp_cnt_pkts", 64'(cnt_pkts), 2);
        chk("tcp_cnt_blocked", 64'(cnt_blocked), 2);
        @(posedge clk); #1;

        // ARP whose bytes 26-29 match block_ip is allowed
        h = mk_head(16'h0806, 4'd5, 8'd6, 32'hC0A8_0001, 16'd80);
        send(h, 64'h0000_0000_0000_003F, 1'b1, 1'b1, 1'b1, w);
        idle();
        @(negedge clk);
        chk("arp_cnt_pkts", 64'(cnt_pkts), 3);
        chk("arp_cnt_blocked", 64'(cnt_blocked), 2);
        @(posedge clk); #1;

        // cfg_enable dropped while a blocked head is stalled
        m_tready = 1'b0;
        h = mk_head(16'h0800, 4'd5, 8'd6, 32'hC0A8_0001, 16'd443);
        send(h, all_keep, 1'b1, 1'b1, 1'b0, w);
        idle();
        cfg_enable = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("held_dvalid", 64'(dec_valid), 1);
            chk("held_allow", 64'(dec_allow), 0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        chk("held_cnt_blocked", 64'(cnt_blocked), 3);

        // Disabled: matching IP allowed
        send(mk_head(16'h0800, 4'd5, 8'd6, 32'hC0A8_0001, 16'd80), all_keep, 1'b1, 1'b1, 1'b1, w);
        // Enabled, port match but ihl=6: allowed
        cfg_enable = 1'b1;
        send(mk_head(16'h0800, 4'd6, 8'd6, 32'h0101_0101, 16'd80), all_keep, 1'b1, 1'b1, 1'b1, w);
        // UDP port match: blocked
        send(mk_head(16'h0800, 4'd5, 8'd17, 32'h0101_0101, 16'd80), all_keep, 1'b1, 1'b1, 1'b0, w);
        // ICMP with port bytes matching: allowed
        send(mk_head(16'h0800, 4'd5, 8'd1, 32'h0101_0101, 16'd80), all_keep, 1'b1, 1'b1, 1'b1, w);
        idle();
        @(negedge clk);
        chk("mix_cnt_pkts", 64'(cnt_pkts), 8);
        chk("mix_cnt_blocked", 64'(cnt_blocked), 4);
        @(posedge clk); #1;

        // Back-to-back single-beat packets at full rate
        @(negedge clk);
        dec0 = dec_cnt;
        @(posedge clk); #1;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                send(mk_head(16'h0800, 4'd5, 8'd17, 32'hC0A8_0001, 16'(1000 + i)), all_keep,
                     1'b1, 1'b1, 1'b0, w);
            else
                send(mk_head(16'h0800, 4'd5, 8'd17, 32'h0202_0202, 16'd53), all_keep,
                     1'b1, 1'b1, 1'b1, w);
            wsum += w;
        end
        idle();
        chk("b2b_stall_cycles", 64'(wsum), 0);
        repeat (2) @(negedge clk);
        chk("b2b_decisions", 64'(dec_cnt - dec0), 8);
        chk("b2b_cnt_pkts", 64'(cnt_pkts), 16);
        chk("b2b_cnt_blocked", 64'(cnt_blocked), 8);
        @(posedge clk); #1;

        // Reset while beat 2 of 4 is held at egress
        send(mk_head(16'h0800, 4'd5, 8'd6, 32'h0303_0303, 16'd1234), all_keep, 1'b0, 1'b1, 1'b1, w);
        send(mk_body(3), all_keep, 1'b0, 1'b0, 1'b0, w);
        m_tready = 1'b0;
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_tvalid), 0);
        chk("mid_rst_dvalid", 64'(dec_valid), 0);
        chk("mid_rst_allow", 64'(dec_allow), 0);
        chk_data("mid_rst_tdata", m_tdata, '0);
        chk("mid_rst_cnt_pkts", 64'(cnt_pkts), 0);
        chk("mid_rst_cnt_blocked", 64'(cnt_blocked), 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        h = mk_head(16'h0800, 4'd5, 8'd6, 32'hC0A8_0001, 16'd22);
        send(h, all_keep, 1'b0, 1'b1, 1'b0, w);
        send(mk_body(4), all_keep, 1'b1, 1'b0, 1'b0, w);
        idle();
        repeat (2) @(negedge clk);
        chk("post_rst_cnt_pkts", 64'(cnt_pkts), 1);
        chk("post_rst_cnt_blocked", 64'(cnt_blocked), 1);
        chk("scoreboard_drained", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
